fetch_pair_queue: RTL and testbench
===================================

Name: fetch_pair_queue

Overview:
- Producer-side buffer feeding the dual-issue decode stage.
- Accepts fetched instruction pairs (inst, PC, predicted-taken and was-fetched flags per slot) from fetch and holds them in a DEPTH-entry FIFO.
- Presents one registered pair per cycle to decode, honouring decode's stall and flushing on any redirect (decode's wasnt-branch correction or a backend mispredict).

Parameters:
- DEPTH, 4, number of pair entries in the FIFO; power of two, minimum 2.
- NOP_INST, 32'h00000013, instruction word driven in bubble slots (addi x0,x0,0).

Ports:
- clock_i  input  1  core clock; all state updates on rising edge.
- reset_n_i  input  1  reset, asynchronous assert, active-low.
- push_valid_i  input  1  fetch offers a pair this cycle.
- push_ready_o  output  1  queue can accept a pair; registered, equals (count < DEPTH).
- inst0_i / inst1_i  input  32 each  fetched instruction words, slot 0 / slot 1.
- pc_0_i / pc_1_i  input  32 each  PCs of slot 0 / slot 1.
- pred_taken_0_i / pred_taken_1_i  input  1 each  BTB/BHT taken prediction per slot.
- was_fetched_0_i / was_fetched_1_i  input  1 each  slot holds a real fetched instruction.
- stall_i  input  1  decode cannot accept a new pair; output stage holds.
- flush_i  input  1  redirect; discard all buffered and presented pairs.
- inst0_o / inst1_o  output  32 each  pair presented to decode.
- pc_0_o / pc_1_o  output  32 each  PCs presented to decode.
- pred_taken_0_o / pred_taken_1_o  output  1 each  predictions presented to decode.
- was_fetched_0_o / was_fetched_1_o  output  1 each  slot-valid flags presented to decode.
- count_o  output  $clog2(DEPTH)+1  current FIFO occupancy, excluding the output stage.

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - count=0, read/write pointers=0, push_ready_o=1.
  - Output stage is a bubble: inst*_o=NOP_INST, pc_*_o=0, pred_taken_*_o=0, was_fetched_*_o=0.
- A push occurs when push_valid_i && push_ready_o. The output stage advances when !stall_i. Each accepted pair is delivered exactly once, in order.
- On advance, the output stage loads:
  - the FIFO head (pop) if count>0;
  - otherwise the input pair directly (bypass) if a push occurs this cycle; the pair is not written into the FIFO;
  - otherwise a bubble.
- Latency: with an empty FIFO and no stall, a pair pushed in cycle N appears on the outputs in cycle N+1.
- Occupancy update:
  - push without pop: count+1.
  - pop without push: count-1.
  - push and pop in the same cycle: count unchanged; write and read both occur.
  - bypass: count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- Full: push_ready_o=0 when count==DEPTH. If stall_i=0 in that cycle, a pop still occurs and push_ready_o returns to 1 in the next cycle. There is no same-cycle push at full.
- Stall: output registers and FIFO head hold. Pushes continue while not full.
- Flush (highest priority, synchronous):
  - count and pointers are cleared and the output stage becomes a bubble in the next cycle.
  - Any push in the flush cycle is dropped.
  - stall_i is ignored in the flush cycle.
  - push_ready_o=1 in the next cycle.
- Fields are stored and forwarded unmodified. The queue does not alter pred_taken; decode performs slot-1 prediction suppression.
- Reset asserted mid-operation: all state returns immediately to the reset values; buffered pairs are lost.

Optional Feature:
- Macro: FETCHQ_STATS_EN.
- Defined:
  - adds output hwm_o ($clog2(DEPTH)+1 bits), the highest count reached since reset. Cleared only by reset; a flush does not clear it.
  - adds output flush_cnt_o (16 bits), the number of flush_i cycles since reset, saturating at 16'hFFFF.
  - Both reset to 0.
- Undefined: neither port nor the associated counters exist; all other behaviour is identical.

Test Plan:
- Bypass: empty queue, stall_i=0; push pair with pc_0=0x100, pc_1=0x104 in cycle N -> outputs show that pair with was_fetched_*_o=1 in N+1; count_o stays 0.
- Fill/stall: stall_i=1; push 4 pairs, pc_0 = 0x100, 0x108, 0x110, 0x118 -> count_o=4, push_ready_o=0. Release stall -> outputs show 0x100, 0x108, 0x110, 0x118 in four consecutive cycles, then bubble (inst0_o=0x00000013).
- Wrap-around: with stall_i=0, push and pop continuously for 10 pairs -> pc_0_o sequence is in order with no duplicates or drops; count_o never exceeds 1.
- Flush: count_o=3, push_valid_i=1 and flush_i=1 in the same cycle -> next cycle count_o=0, was_fetched_*_o=0, push_ready_o=1; the pushed pair never appears on the outputs.
- Async reset: assert reset_n_i mid-cycle with count_o=2 -> outputs are bubble and count_o=0 immediately, without waiting for a clock edge.
- FETCHQ_STATS_EN defined: fill to 3, flush twice, fill to 1 -> hwm_o=3, flush_cnt_o=2.

Source files
------------

// File: rtl/fetch_pair_queue.sv
// Instruction-pair queue between fetch and dual-issue decode, with a registered output stage.
// Optional occupancy high-water mark and flush counter when FETCHQ_STATS_EN is defined.
module fetch_pair_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [31:0]                inst0_i,
  input  logic [31:0]                inst1_i,
  input  logic [31:0]                pc_0_i,
  input  logic [31:0]                pc_1_i,
  input  logic                       pred_taken_0_i,
  input  logic                       pred_taken_1_i,
  input  logic                       was_fetched_0_i,
  input  logic                       was_fetched_1_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic [31:0]                inst0_o,
  output logic [31:0]                inst1_o,
  output logic [31:0]                pc_0_o,
  output logic [31:0]                pc_1_o,
  output logic                       pred_taken_0_o,
  output logic                       pred_taken_1_o,
  output logic                       was_fetched_0_o,
  output logic                       was_fetched_1_o,
  output logic [$clog2(DEPTH):0]     count_o
`ifdef FETCHQ_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]     hwm_o,
  output logic [15:0]                flush_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        pt0;
    logic        pt1;
    logic        wf0;
    logic        wf1;
  } pair_t;

  localparam pair_t BUBBLE = '{NOP_INST, NOP_INST, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  pair_t          mem_q [DEPTH];
  pair_t          in_pair;
  pair_t          out_q, out_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ready_q, ready_d;
  logic           push, adv, pop, bypass, wr_en;

  assign in_pair = '{inst0_i, inst1_i, pc_0_i, pc_1_i,
                     pred_taken_0_i, pred_taken_1_i, was_fetched_0_i, was_fetched_1_i};

  always_comb begin
    push     = push_valid_i && ready_q && !flush_i;
    adv      = !stall_i;
    pop      = adv && (count_q != '0);
    // An empty queue hands the incoming pair straight to the output stage.
    bypass   = adv && (count_q == '0) && push;
    wr_en    = push && !bypass;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      out_d    = BUBBLE;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_d = count_q + 1'b1;
      else if (pop && !wr_en) count_d = count_q - 1'b1;
      if (adv) out_d = pop ? mem_q[rd_ptr_q] : (bypass ? in_pair : BUBBLE);
    end
    ready_d = (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      out_q    <= BUBBLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      out_q    <= out_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_pair;
  end

  assign push_ready_o    = ready_q;
  assign count_o         = count_q;
  assign inst0_o         = out_q.inst0;
  assign inst1_o         = out_q.inst1;
  assign pc_0_o          = out_q.pc0;
  assign pc_1_o          = out_q.pc1;
  assign pred_taken_0_o  = out_q.pt0;
  assign pred_taken_1_o  = out_q.pt1;
  assign was_fetched_0_o = out_q.wf0;
  assign was_fetched_1_o = out_q.wf1;

`ifdef FETCHQ_STATS_EN
  logic [CW-1:0] hwm_q, hwm_d;
  logic [15:0]   flush_cnt_q, flush_cnt_d;

  always_comb begin
    hwm_d       = (count_d > hwm_q) ? count_d : hwm_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_i && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hwm_q       <= '0;
      flush_cnt_q <= '0;
    end else begin
      hwm_q       <= hwm_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hwm_o       = hwm_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Self-checking bench for fetch_pair_queue: vector table, directed corner sequences, random vs queue model.
// Build with FETCHQ_STATS_EN defined to also exercise the statistics outputs.
module tb_fetch_pair_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk, rst_n;
  logic        push_valid, push_ready;
  logic [31:0] inst0, inst1, pc0, pc1;
  logic        pt0, pt1, wf0, wf1, stall, flush;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic        pt0_o, pt1_o, wf0_o, wf1_o;
  logic [2:0]  count_o;
`ifdef FETCHQ_STATS_EN
  logic [2:0]  hwm_o;
  logic [15:0] fcnt_o;
`endif

  fetch_pair_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .push_valid_i(push_valid), .push_ready_o(push_ready),
    .inst0_i(inst0), .inst1_i(inst1), .pc_0_i(pc0), .pc_1_i(pc1),
    .pred_taken_0_i(pt0), .pred_taken_1_i(pt1),
    .was_fetched_0_i(wf0), .was_fetched_1_i(wf1),
    .stall_i(stall), .flush_i(flush),
    .inst0_o(inst0_o), .inst1_o(inst1_o), .pc_0_o(pc0_o), .pc_1_o(pc1_o),
    .pred_taken_0_o(pt0_o), .pred_taken_1_o(pt1_o),
    .was_fetched_0_o(wf0_o), .was_fetched_1_o(wf1_o),
    .count_o(count_o)
`ifdef FETCHQ_STATS_EN
    , .hwm_o(hwm_o), .flush_cnt_o(fcnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        pt0;
    logic        pt1;
    logic        wf0;
    logic        wf1;
  } pair_t;

  localparam pair_t BUB = '{NOP, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Reference model: an ordered queue of pairs plus the presented pair.
  pair_t mq[$];
  pair_t mout;
  bit    mready;
  int    mhwm, mfcnt;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return p ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mout = BUB;
    mready = 1'b1;
    mhwm = 0;
    mfcnt = 0;
  endtask

  task automatic model_step();
    pair_t inp;
    bit    pu, used;
    inp = '{inst0, inst1, pc0, pc1, pt0, pt1, wf0, wf1};
    if (flush) begin
      mq.delete();
      mout = BUB;
      mready = 1'b1;
      if (mfcnt < 65535) mfcnt++;
    end else begin
      pu = push_valid && mready;
      used = 1'b0;
      if (!stall) begin
        if (mq.size() > 0) mout = mq.pop_front();
        else if (pu) begin mout = inp; used = 1'b1; end
        else mout = BUB;
      end
      if (pu && !used) mq.push_back(inp);
      mready = (mq.size() < DEPTH);
      if (mq.size() > mhwm) mhwm = mq.size();
    end
  endtask

  task automatic drive(input bit v, input bit s, input bit f, input logic [31:0] pc);
    push_valid = v; stall = s; flush = f;
    pc0 = pc; pc1 = pc + 32'd4;
    inst0 = inst_of(pc); inst1 = inst_of(pc + 32'd4);
    pt0 = 1'b0; pt1 = 1'b0; wf0 = 1'b1; wf1 = 1'b1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 32'd0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_inst0"}, inst0_o, mout.inst0);
    chk({tag, "_inst1"}, inst1_o, mout.inst1);
    chk({tag, "_pc0"}, pc0_o, mout.pc0);
    chk({tag, "_pc1"}, pc1_o, mout.pc1);
    chk({tag, "_flags"}, {28'd0, pt0_o, pt1_o, wf0_o, wf1_o},
        {28'd0, mout.pt0, mout.pt1, mout.wf0, mout.wf1});
    chk({tag, "_count"}, 32'(count_o), 32'(mq.size()));
    chk({tag, "_ready"}, 32'(push_ready), 32'(mready));
`ifdef FETCHQ_STATS_EN
    chk({tag, "_hwm"}, 32'(hwm_o), 32'(mhwm));
    chk({tag, "_fcnt"}, 32'(fcnt_o), 32'(mfcnt));
`endif
  endtask

  typedef struct {
    bit          v;
    bit          s;
    logic [31:0] pc;
    logic [31:0] e_pc;
    bit          e_wf;
    int          e_cnt;
    bit          e_rdy;
  } vec_t;

  vec_t tv[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // bypass, then fill under stall, then drain
    tv[0]  = '{1, 0, 32'h100, 32'h100, 1, 0, 1};
    tv[1]  = '{0, 0, 32'h0,   32'h0,   0, 0, 1};
    tv[2]  = '{1, 1, 32'h100, 32'h0,   0, 1, 1};
    tv[3]  = '{1, 1, 32'h108, 32'h0,   0, 2, 1};
    tv[4]  = '{1, 1, 32'h110, 32'h0,   0, 3, 1};
    tv[5]  = '{1, 1, 32'h118, 32'h0,   0, 4, 0};
    tv[6]  = '{1, 0, 32'h120, 32'h100, 1, 3, 1};
    tv[7]  = '{0, 0, 32'h0,   32'h108, 1, 2, 1};
    tv[8]  = '{0, 0, 32'h0,   32'h110, 1, 1, 1};
    tv[9]  = '{0, 0, 32'h0,   32'h118, 1, 0, 1};
    tv[10] = '{0, 0, 32'h0,   32'h0,   0, 0, 1};

    do_reset();
    chk("reset_count", 32'(count_o), 32'd0);
    chk("reset_ready", 32'(push_ready), 32'd1);
    chk("reset_inst0", inst0_o, NOP);
    chk("reset_wf", {30'd0, wf0_o, wf1_o}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].v, tv[i].s, 0, tv[i].pc);
      step();
      chk($sformatf("vec%0d_pc0", i), pc0_o, tv[i].e_pc);
      chk($sformatf("vec%0d_pc1", i), pc1_o, tv[i].e_wf ? tv[i].e_pc + 32'd4 : 32'd0);
      chk($sformatf("vec%0d_inst0", i), inst0_o, tv[i].e_wf ? inst_of(tv[i].e_pc) : NOP);
      chk($sformatf("vec%0d_wf", i), {30'd0, wf0_o, wf1_o}, tv[i].e_wf ? 32'd3 : 32'd0);
      chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(tv[i].e_cnt));
      chk($sformatf("vec%0d_ready", i), 32'(push_ready), 32'(tv[i].e_rdy));
    end

    // continuous push+pop at occupancy 1 walks the pointers through several wraps
    do_reset();
    drive(1, 1, 0, 32'h200);
    step();
    chk("wrap_prime_count", 32'(count_o), 32'd1);
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 0, 32'h208 + 32'(8 * k));
      step();
      chk($sformatf("wrap%0d_pc0", k), pc0_o, 32'h200 + 32'(8 * k));
      chk($sformatf("wrap%0d_count", k), 32'(count_o), 32'd1);
    end
    drive(0, 0, 0, 32'd0);
    step();
    chk("wrap_last_pc0", pc0_o, 32'h250);
    chk("wrap_last_count", 32'(count_o), 32'd0);

    // flush with a simultaneous push at count 3
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 32'h300 + 32'(8 * k));
      step();
    end
    chk("flush_pre_count", 32'(count_o), 32'd3);
    drive(1, 1, 1, 32'h999);
    step();
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_wf", {30'd0, wf0_o, wf1_o}, 32'd0);
    chk("flush_ready", 32'(push_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 32'd0);
      step();
      chk($sformatf("flush_after%0d_wf", k), {30'd0, wf0_o, wf1_o}, 32'd0);
      chk($sformatf("flush_after%0d_count", k), 32'(count_o), 32'd0);
    end

    // asynchronous reset between clock edges
    do_reset();
    drive(1, 0, 0, 32'h400);
    step();
    drive(1, 1, 0, 32'h408);
    step();
    drive(1, 1, 0, 32'h410);
    step();
    chk("areset_pre_count", 32'(count_o), 32'd2);
    chk("areset_pre_wf", {31'd0, wf0_o}, 32'd1);
    drive(0, 0, 0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_count", 32'(count_o), 32'd0);
    chk("areset_inst0", inst0_o, NOP);
    chk("areset_pc0", pc0_o, 32'd0);
    chk("areset_wf", {30'd0, wf0_o, wf1_o}, 32'd0);
    chk("areset_ready", 32'(push_ready), 32'd1);
    do_reset();

`ifdef FETCHQ_STATS_EN
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 32'h500 + 32'(8 * k));
      step();
    end
    drive(0, 1, 1, 32'd0);
    step();
    step();
    drive(1, 1, 0, 32'h600);
    step();
    chk("stats_count", 32'(count_o), 32'd1);
    chk("stats_hwm", 32'(hwm_o), 32'd3);
    chk("stats_fcnt", 32'(fcnt_o), 32'd2);
    do_reset();
    chk("stats_reset_hwm", 32'(hwm_o), 32'd0);
`endif

    // randomized traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      push_valid = ($urandom % 4) != 0;
      stall      = ($urandom % 3) == 0;
      flush      = ($urandom % 25) == 0;
      inst0 = $urandom; inst1 = $urandom;
      pc0   = $urandom; pc1   = $urandom;
      pt0 = $urandom % 2; pt1 = $urandom % 2;
      wf0 = $urandom % 2; wf1 = $urandom % 2;
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
